// File: rtl/turing_machine_gen_if.sv
// Handshake and observation bundle for turing_machine_gen: table/step inputs
// from the master side, registered machine state back to it.
interface turing_machine_gen_if #(
  parameter int STATE_BITS = 2,
  parameter int TAPE_LEN   = 8,
  parameter int STEP_LIMIT = 16
);
  localparam int HEAD_W = $clog2(TAPE_LEN);
  localparam int CNT_W  = $clog2(STEP_LIMIT + 1);

  logic [STATE_BITS+2:0] input_data;
  logic                  Next;
  logic                  Done;
  logic                  run_mode;
  logic [STATE_BITS-1:0] next_state_out;
  logic [1:0]            direction;
  logic [HEAD_W-1:0]     head_pos;
  logic [TAPE_LEN-1:0]   data_reg_out;
  logic [CNT_W-1:0]      step_count;
  logic                  loading;
  logic                  halted;
  logic [1:0]            fault;

  modport master (
    output input_data, Next, Done, run_mode,
    input  next_state_out, direction, head_pos, data_reg_out,
           step_count, loading, halted, fault
  );

  modport slave (
    input  input_data, Next, Done, run_mode,
    output next_state_out, direction, head_pos, data_reg_out,
           step_count, loading, halted, fault
  );
endinterface

// File: rtl/turing_machine_gen.sv
// Binary-tape Turing machine with a loadable transition table, single-step or
// free-run execution, halt detection, tape-edge fault and step-limit watchdog.
module turing_machine_gen #(
  parameter int STATE_BITS = 2,
  parameter int TAPE_LEN   = 8,
  parameter int START_POS  = 0,
  parameter int STEP_LIMIT = 16
) (
  input  logic                clock,
  input  logic                Reset_n,
  turing_machine_gen_if.slave bus
);
  localparam int ENTRY_W   = STATE_BITS + 3;
  localparam int N_ENTRIES = 2 * ((1 << STATE_BITS) - 1);
  localparam int PTR_W     = $clog2(N_ENTRIES + 1);
  localparam int HEAD_W    = $clog2(TAPE_LEN);
  localparam int CNT_W     = $clog2(STEP_LIMIT + 1);
  localparam int IDX_W     = STATE_BITS + 1;

  localparam logic [HEAD_W-1:0]     HEAD_START = HEAD_W'(START_POS);
  localparam logic [HEAD_W-1:0]     HEAD_LAST  = HEAD_W'(TAPE_LEN - 1);
  localparam logic [HEAD_W-1:0]     HEAD_ONE   = HEAD_W'(1);
  localparam logic [CNT_W-1:0]      CNT_LIMIT  = CNT_W'(STEP_LIMIT);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0]      PTR_FULL   = PTR_W'(N_ENTRIES);
  localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);
  localparam logic [STATE_BITS-1:0] STATE_INIT = STATE_BITS'(1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } fsm_e;

  fsm_e                              fsm_q, fsm_d;
  logic [N_ENTRIES-1:0][ENTRY_W-1:0] table_q, table_d;
  logic [PTR_W-1:0]                  ptr_q, ptr_d;
  logic [TAPE_LEN-1:0]               tape_q, tape_d;
  logic [HEAD_W-1:0]                 head_q, head_d;
  logic [STATE_BITS-1:0]             state_q, state_d;
  logic [1:0]                        dir_q, dir_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [1:0]                        fault_q, fault_d;
  logic                              loading_q, loading_d;
  logic                              halted_q, halted_d;
  logic                              next_q, done_q;

  logic                  nxt, dn, step_req, do_step, do_restart;
  logic                  rd_bit, edge_hit;
  logic [IDX_W-1:0]      entry_idx;
  logic [ENTRY_W-1:0]    cur_entry;
  logic [STATE_BITS-1:0] e_next;
  logic [1:0]            e_dir;
  logic                  e_write;
  logic [HEAD_W-1:0]     head_move;
  logic [CNT_W-1:0]      cnt_inc;

  assign nxt = bus.Next & ~next_q;
  assign dn  = bus.Done & ~done_q;

  // Table lookup for the current (state, read bit); state 0 never steps, so it maps to a halt entry.
  always_comb begin
    rd_bit    = tape_q[head_q];
    entry_idx = {state_q - STATE_INIT, rd_bit};
    if (state_q == '0) begin
      cur_entry = '0;
    end else begin
      cur_entry = table_q[entry_idx];
    end
    e_next  = cur_entry[ENTRY_W-1:3];
    e_dir   = cur_entry[2:1];
    e_write = cur_entry[0];
    cnt_inc = cnt_q + CNT_ONE;

    head_move = head_q;
    edge_hit  = 1'b0;
    case (e_dir)
      2'b01: begin
        if (head_q == '0) begin
          edge_hit = 1'b1;
        end else begin
          head_move = head_q - HEAD_ONE;
        end
      end
      2'b10: begin
        if (head_q == HEAD_LAST) begin
          edge_hit = 1'b1;
        end else begin
          head_move = head_q + HEAD_ONE;
        end
      end
      default: head_move = head_q;
    endcase
  end

  // Next-state logic: decide load/step/restart, then apply the chosen action.
  always_comb begin
    fsm_d      = fsm_q;
    table_d    = table_q;
    ptr_d      = ptr_q;
    tape_d     = tape_q;
    head_d     = head_q;
    state_d    = state_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    fault_d    = fault_q;
    do_step    = 1'b0;
    do_restart = 1'b0;
    step_req   = bus.run_mode ? 1'b1 : nxt;

    case (fsm_q)
      S_LOAD: begin
        // Writes saturate at the table size so entry 0 is never overwritten by a wrap.
        if (nxt && (ptr_q < PTR_FULL)) begin
          table_d[ptr_q] = bus.input_data;
          ptr_d          = ptr_q + PTR_ONE;
        end else begin
          ptr_d = ptr_q;
        end
        if (dn) begin
          fsm_d = S_RUN;
        end else begin
          fsm_d = S_LOAD;
        end
      end
      S_RUN: begin
        if (dn) begin
          do_restart = 1'b1;
        end else if (step_req) begin
          do_step = 1'b1;
        end else begin
          fsm_d = S_RUN;
        end
      end
      S_HALT, S_FAULT: begin
        if (dn) begin
          do_restart = 1'b1;
        end else begin
          fsm_d = fsm_q;
        end
      end
      default: fsm_d = S_LOAD;
    endcase

    if (do_restart) begin
      fsm_d   = S_RUN;
      tape_d  = '0;
      head_d  = HEAD_START;
      state_d = STATE_INIT;
      dir_d   = 2'b00;
      cnt_d   = '0;
      fault_d = 2'b00;
    end else if (do_step) begin
      tape_d[head_q] = e_write;
      state_d        = e_next;
      dir_d          = e_dir;
      cnt_d          = cnt_inc;
      head_d         = head_move;
      // Exit priority: halt, then tape edge, then watchdog.
      if (e_next == '0) begin
        fsm_d = S_HALT;
      end else if (edge_hit) begin
        fsm_d   = S_FAULT;
        fault_d = 2'b01;
      end else if (cnt_inc == CNT_LIMIT) begin
        fsm_d   = S_FAULT;
        fault_d = 2'b10;
      end else begin
        fsm_d = S_RUN;
      end
    end else begin
      fault_d = fault_q;
    end

    loading_d = (fsm_d == S_LOAD);
    halted_d  = (fsm_d == S_HALT);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!Reset_n) begin
      fsm_q     <= S_LOAD;
      table_q   <= '0;
      ptr_q     <= '0;
      tape_q    <= '0;
      head_q    <= HEAD_START;
      state_q   <= STATE_INIT;
      dir_q     <= 2'b00;
      cnt_q     <= '0;
      fault_q   <= 2'b00;
      loading_q <= 1'b1;
      halted_q  <= 1'b0;
      next_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      table_q   <= table_d;
      ptr_q     <= ptr_d;
      tape_q    <= tape_d;
      head_q    <= head_d;
      state_q   <= state_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      loading_q <= loading_d;
      halted_q  <= halted_d;
      next_q    <= bus.Next;
      done_q    <= bus.Done;
    end
  end

  assign bus.next_state_out = state_q;
  assign bus.direction      = dir_q;
  assign bus.head_pos       = head_q;
  assign bus.data_reg_out   = tape_q;
  assign bus.step_count     = cnt_q;
  assign bus.loading        = loading_q;
  assign bus.halted         = halted_q;
  assign bus.fault          = fault_q;
endmodule

// File: tb/tb_turing_machine_gen.sv
// Directed bench for turing_machine_gen: cycle table for a full load/run/halt,
// plus hand sequences for faults, watchdog, restart, held inputs and reset.
module tb_turing_machine_gen;
  logic clock;
  logic Reset_n;
  int   checks;
  int   errors;

  turing_machine_gen_if #(.STATE_BITS(2), .TAPE_LEN(8), .STEP_LIMIT(16)) bus ();

  turing_machine_gen #(
    .STATE_BITS(2),
    .TAPE_LEN  (8),
    .START_POS (0),
    .STEP_LIMIT(16)
  ) dut (
    .clock  (clock),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] data;
    logic       nx;
    logic       dn;
    logic [1:0] e_state;
    logic [1:0] e_dir;
    logic [2:0] e_head;
    logic [7:0] e_tape;
    logic [4:0] e_cnt;
    logic       e_ld;
    logic       e_hl;
    logic [1:0] e_flt;
  } vec_t;

  vec_t vq[$];

  // state1/r0: w1,R,->2 ; state2/r0: w1,R,->3 ; state3/r0: w1,stay,->halt
  logic [4:0] prog [6] = '{5'd21, 5'd0, 5'd29, 5'd0, 5'd7, 5'd0};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [1:0] dr,
                           input logic [2:0] hd, input logic [7:0] tp, input logic [4:0] ct,
                           input logic ld, input logic hl, input logic [1:0] fl);
    chk({tag, ".state"},   32'(bus.next_state_out), 32'(st));
    chk({tag, ".dir"},     32'(bus.direction),      32'(dr));
    chk({tag, ".head"},    32'(bus.head_pos),       32'(hd));
    chk({tag, ".tape"},    32'(bus.data_reg_out),   32'(tp));
    chk({tag, ".count"},   32'(bus.step_count),     32'(ct));
    chk({tag, ".loading"}, 32'(bus.loading),        32'(ld));
    chk({tag, ".halted"},  32'(bus.halted),         32'(hl));
    chk({tag, ".fault"},   32'(bus.fault),          32'(fl));
  endtask

  function automatic void add(input logic [4:0] d, input logic n, input logic o,
                              input logic [1:0] st, input logic [1:0] dr, input logic [2:0] hd,
                              input logic [7:0] tp, input logic [4:0] ct, input logic ld,
                              input logic hl, input logic [1:0] fl);
    vec_t v;
    v.data = d; v.nx = n; v.dn = o;
    v.e_state = st; v.e_dir = dr; v.e_head = hd; v.e_tape = tp;
    v.e_cnt = ct; v.e_ld = ld; v.e_hl = hl; v.e_flt = fl;
    vq.push_back(v);
  endfunction

  task automatic do_reset();
    Reset_n        = 1'b0;
    bus.Next       = 1'b0;
    bus.Done       = 1'b0;
    bus.run_mode   = 1'b0;
    bus.input_data = 5'd0;
    tick();
    tick();
    Reset_n = 1'b1;
  endtask

  task automatic press_next(input logic [4:0] d);
    bus.input_data = d;
    bus.Next       = 1'b1;
    tick();
    bus.Next       = 1'b0;
    tick();
  endtask

  task automatic press_done();
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    tick();
  endtask

  task automatic load_prog();
    for (int k = 0; k < 6; k++) press_next(prog[k]);
  endtask

  initial begin
    clock          = 1'b0;
    checks         = 0;
    errors         = 0;
    Reset_n        = 1'b0;
    bus.Next       = 1'b0;
    bus.Done       = 1'b0;
    bus.run_mode   = 1'b0;
    bus.input_data = 5'd0;

    do_reset();
    check_all("reset", 2'd1, 2'd0, 3'd0, 8'h00, 5'd0, 1'b1, 1'b0, 2'd0);

    // Cycle table: load six entries, Done, three single steps to halt, ignored Next.
    for (int k = 0; k < 6; k++) begin
      add(prog[k], 1'b1, 1'b0, 2'd1, 2'd0, 3'd0, 8'h00, 5'd0, 1'b1, 1'b0, 2'd0);
      add(prog[k], 1'b0, 1'b0, 2'd1, 2'd0, 3'd0, 8'h00, 5'd0, 1'b1, 1'b0, 2'd0);
    end
    add(5'd0, 1'b0, 1'b1, 2'd1, 2'd0, 3'd0, 8'h00, 5'd0, 1'b0, 1'b0, 2'd0);
    add(5'd0, 1'b0, 1'b0, 2'd1, 2'd0, 3'd0, 8'h00, 5'd0, 1'b0, 1'b0, 2'd0);
    add(5'd0, 1'b1, 1'b0, 2'd2, 2'd2, 3'd1, 8'h01, 5'd1, 1'b0, 1'b0, 2'd0);
    add(5'd0, 1'b0, 1'b0, 2'd2, 2'd2, 3'd1, 8'h01, 5'd1, 1'b0, 1'b0, 2'd0);
    add(5'd0, 1'b1, 1'b0, 2'd3, 2'd2, 3'd2, 8'h03, 5'd2, 1'b0, 1'b0, 2'd0);
    add(5'd0, 1'b0, 1'b0, 2'd3, 2'd2, 3'd2, 8'h03, 5'd2, 1'b0, 1'b0, 2'd0);
    add(5'd0, 1'b1, 1'b0, 2'd0, 2'd3, 3'd2, 8'h07, 5'd3, 1'b0, 1'b1, 2'd0);
    add(5'd0, 1'b0, 1'b0, 2'd0, 2'd3, 3'd2, 8'h07, 5'd3, 1'b0, 1'b1, 2'd0);
    add(5'd0, 1'b1, 1'b0, 2'd0, 2'd3, 3'd2, 8'h07, 5'd3, 1'b0, 1'b1, 2'd0);
    add(5'd0, 1'b0, 1'b0, 2'd0, 2'd3, 3'd2, 8'h07, 5'd3, 1'b0, 1'b1, 2'd0);

    for (int i = 0; i < vq.size(); i++) begin
      bus.input_data = vq[i].data;
      bus.Next       = vq[i].nx;
      bus.Done       = vq[i].dn;
      tick();
      check_all($sformatf("vec%0d", i), vq[i].e_state, vq[i].e_dir, vq[i].e_head,
                vq[i].e_tape, vq[i].e_cnt, vq[i].e_ld, vq[i].e_hl, vq[i].e_flt);
    end

    // Restart after halt keeps the table and reproduces the same run.
    press_done();
    check_all("restart", 2'd1, 2'd0, 3'd0, 8'h00, 5'd0, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 3; k++) press_next(5'd0);
    check_all("rerun", 2'd0, 2'd3, 3'd2, 8'h07, 5'd3, 1'b0, 1'b1, 2'd0);

    // Next held high for five clocks gives exactly one step.
    press_done();
    bus.Next = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check_all("held_next", 2'd2, 2'd2, 3'd1, 8'h01, 5'd1, 1'b0, 1'b0, 2'd0);
    bus.Next = 1'b0;
    tick();

    // Left move off cell 0: write/state/count commit, head holds, edge fault.
    do_reset();
    press_next(5'b01011);
    press_done();
    press_next(5'd0);
    check_all("edge", 2'd1, 2'd1, 3'd0, 8'h01, 5'd1, 1'b0, 1'b0, 2'd1);
    press_next(5'd0);
    check_all("edge_hold", 2'd1, 2'd1, 3'd0, 8'h01, 5'd1, 1'b0, 1'b0, 2'd1);

    // Free-run watchdog: self loop trips after exactly 16 steps.
    do_reset();
    press_next(5'b01110);
    bus.run_mode = 1'b1;
    bus.Done     = 1'b1;
    tick();
    bus.Done = 1'b0;
    check_all("free_start", 2'd1, 2'd0, 3'd0, 8'h00, 5'd0, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 15; k++) tick();
    check_all("free_15", 2'd1, 2'd3, 3'd0, 8'h00, 5'd15, 1'b0, 1'b0, 2'd0);
    tick();
    check_all("watchdog", 2'd1, 2'd3, 3'd0, 8'h00, 5'd16, 1'b0, 1'b0, 2'd2);
    for (int k = 0; k < 3; k++) tick();
    check_all("wd_hold", 2'd1, 2'd3, 3'd0, 8'h00, 5'd16, 1'b0, 1'b0, 2'd2);
    bus.run_mode = 1'b0;

    // Next and Done on the same edge: entry written and run entered together.
    do_reset();
    bus.input_data = 5'd21;
    bus.Next       = 1'b1;
    bus.Done       = 1'b1;
    tick();
    check_all("same_edge", 2'd1, 2'd0, 3'd0, 8'h00, 5'd0, 1'b0, 1'b0, 2'd0);
    bus.Next = 1'b0;
    bus.Done = 1'b0;
    tick();
    press_next(5'd0);
    check_all("same_edge_step", 2'd2, 2'd2, 3'd1, 8'h01, 5'd1, 1'b0, 1'b0, 2'd0);

    // Reset mid-run aborts; reload saturates with the seventh Next ignored.
    do_reset();
    load_prog();
    press_done();
    press_next(5'd0);
    Reset_n = 1'b0;
    tick();
    check_all("mid_reset", 2'd1, 2'd0, 3'd0, 8'h00, 5'd0, 1'b1, 1'b0, 2'd0);
    Reset_n = 1'b1;
    tick();
    load_prog();
    press_next(5'b01011);
    check_all("saturate", 2'd1, 2'd0, 3'd0, 8'h00, 5'd0, 1'b1, 1'b0, 2'd0);
    press_done();
    for (int k = 0; k < 3; k++) press_next(5'd0);
    check_all("reload_run", 2'd0, 2'd3, 3'd2, 8'h07, 5'd3, 1'b0, 1'b1, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
